// File: rtl/spi_pkg.sv
// Frame constants and FSM state type shared by the SPI register-bank target.
package spi_pkg;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // Rise numbers (1-based) of the first address bit, first write-data bit and read turnaround.
  localparam int unsigned ADDR_FIRST = 2;

  function automatic int unsigned wdata_first(input int unsigned a);
    return a + 2;
  endfunction

  function automatic int unsigned turnaround(input int unsigned a);
    return a + 2;
  endfunction

  typedef enum logic [2:0] {IDLE, OP, ADDR, WDATA, RDATA} spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser for one SPI pin, with a third flop for edge detection.
module spi_in_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_d};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];
  assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI target decoding write/read frames into a bank of NREG D-bit control registers.
// SPI pins are oversampled by the system clock; nothing here is clocked by SCLK.
module spi_slave_regbank
  import spi_pkg::*;
#(
  parameter int unsigned D    = 8,
  parameter int unsigned A    = 8,
  parameter int unsigned NREG = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ss,
  input  logic                i_sclk,
  input  logic                i_mosi,
  output logic                o_miso,
  output logic [NREG*D-1:0]   o_regs,
  output logic                o_wr_stb,
  output logic [A-1:0]        o_wr_addr
);

  // Counter thresholds are compared against the count *before* the current rise.
  localparam logic [7:0] ADDR_LAST_CNT = 8'(A + ADDR_FIRST - 2);
  localparam logic [7:0] WDATA_END_CNT = 8'(wdata_first(A) + D - 1);
  localparam logic [7:0] TURN_CNT      = 8'(turnaround(A));
  localparam int unsigned IDXW         = (NREG > 1) ? $clog2(NREG) : 1;

  logic w_ss, w_ss_rise, w_ss_fall_unused;
  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_in_sync u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss),
    .o_level(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall_unused)
  );

  spi_in_sync u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
    .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_in_sync u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_t   r_state;
  logic         r_ss_armed;
  logic         r_op;
  logic [7:0]   r_cnt;
  logic [A-1:0] r_addr_sr;
  logic [D-1:0] r_data_sr;
  logic [D-1:0] r_rd_sr;
  logic         r_miso;
  logic         r_wr_stb;
  logic [A-1:0] r_wr_addr;
  logic [D-1:0] r_regs [NREG];

  logic         w_addr_hit;
  logic [D-1:0] w_rd_word;
  logic [D-1:0] w_rd_next;

  assign w_addr_hit = 32'(r_addr_sr) < NREG;
  assign w_rd_word  = w_addr_hit ? r_regs[r_addr_sr[IDXW-1:0]] : '0;
  assign w_rd_next  = r_rd_sr >> 1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ss_armed <= 1'b0;
      r_op       <= OP_READ;
      r_cnt      <= '0;
      r_addr_sr  <= '0;
      r_data_sr  <= '0;
      r_rd_sr    <= '0;
      r_miso     <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      // A frame may only start after SS has been seen high, so a reset mid-frame waits it out.
      if (w_ss) r_ss_armed <= 1'b1;
      if (r_state != IDLE && !w_ss && w_sclk_rise && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;

      if (r_state != IDLE && w_ss_rise) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
        r_rd_sr <= '0;
        if (r_op == OP_WRITE && r_cnt == WDATA_END_CNT) begin
          r_wr_stb  <= 1'b1;
          r_wr_addr <= r_addr_sr;
          if (w_addr_hit) r_regs[r_addr_sr[IDXW-1:0]] <= r_data_sr;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_rd_sr <= '0;
            r_op    <= OP_READ;
            if (!w_ss && r_ss_armed) begin
              r_state    <= OP;
              r_ss_armed <= 1'b0;
            end
          end
          OP: begin
            if (w_sclk_rise) begin
              r_op    <= w_mosi ? OP_WRITE : OP_READ;
              r_state <= ADDR;
            end
          end
          ADDR: begin
            if (w_sclk_rise) begin
              // LSB-first: each bit enters at the top and settles at its index after A shifts.
              r_addr_sr <= (r_addr_sr >> 1) | (A'(w_mosi) << (A - 1));
              if (r_cnt == ADDR_LAST_CNT) r_state <= (r_op == OP_WRITE) ? WDATA : RDATA;
            end
          end
          WDATA: begin
            if (w_sclk_rise && r_cnt < WDATA_END_CNT) begin
              r_data_sr <= (r_data_sr >> 1) | (D'(w_mosi) << (D - 1));
            end
          end
          RDATA: begin
            if (w_sclk_fall) begin
              if (r_cnt < TURN_CNT) begin
                r_rd_sr <= w_rd_word;
                r_miso  <= w_rd_word[0];
              end else begin
                r_rd_sr <= w_rd_next;
                r_miso  <= w_rd_next[0];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_out
      assign o_regs[gi*D +: D] = r_regs[gi];
    end
  endgenerate

  assign o_miso    = r_miso;
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_addr = r_wr_addr;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: a bit-level SPI master plus a register-array model of the bank.
module tb_spi_slave_regbank;

  localparam int D    = 8;
  localparam int A    = 8;
  localparam int NREG = 16;
  localparam int NW   = A + D + 1;
  localparam int NR   = A + D + 2;

  typedef logic [NREG*D-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ss = 1'b1;
  logic             sclk = 1'b0;
  logic             mosi = 1'b0;
  logic             miso;
  logic [NREG*D-1:0] regs;
  logic             wr_stb;
  logic [A-1:0]     wr_addr;

  always #5 clk = ~clk;

  spi_slave_regbank #(.D(D), .A(A), .NREG(NREG)) dut (
    .i_clk(clk), .i_rst(rst), .i_ss(ss), .i_sclk(sclk), .i_mosi(mosi),
    .o_miso(miso), .o_regs(regs), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr)
  );

  int total = 0;
  int bad = 0;
  logic [D-1:0] model [NREG];
  logic [A-1:0] model_last_addr = '0;
  bit settled = 1'b0;
  int stb_cnt = 0;
  bit stb_prev = 1'b0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model_flat();
    vec_t f = '0;
    for (int k = 0; k < NREG; k++) f[k*D +: D] = model[k];
    return f;
  endfunction

  // Per-cycle compare, sampled 1ns after the active edge.
  always @(posedge clk) begin
    #1;
    if (wr_stb) begin
      stb_cnt++;
      check("stb_one_cycle", vec_t'(stb_prev), '0);
    end
    if (rst) begin
      check("rst_regs", regs, '0);
      check("rst_miso", vec_t'(miso), '0);
      check("rst_stb", vec_t'(wr_stb), '0);
    end else if (settled) begin
      check("idle_regs", regs, model_flat());
      check("idle_miso", vec_t'(miso), '0);
    end
    stb_prev = wr_stb;
  end

  // One SPI frame of nrises SCLK rises; rst_at (>0) pulses reset while SCLK is high on that rise.
  task automatic frame(input bit op, input logic [A-1:0] addr, input logic [D-1:0] data,
                       input int nrises, input int rst_at, output logic [D-1:0] rx);
    bit bits[$];
    bit reset_hit = 1'b0;
    bit commit;
    bits.push_back(op);
    for (int i = 0; i < A; i++) bits.push_back(addr[i]);
    if (op) begin
      for (int i = 0; i < D; i++) bits.push_back(data[i]);
    end
    while (bits.size() < nrises) bits.push_back(1'($urandom_range(0, 1)));
    rx = '0;
    settled = 1'b0;
    stb_cnt = 0;
    ss = 1'b0;
    #40;
    for (int r = 1; r <= nrises; r++) begin
      mosi = bits[r-1];
      #40;
      sclk = 1'b1;
      if (r == rst_at) begin
        #10;
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #10;
        for (int k = 0; k < NREG; k++) model[k] = '0;
        model_last_addr = '0;
        reset_hit = 1'b1;
        check("regs_after_rst", regs, '0);
      end else begin
        #40;
      end
      if (r >= A + 2 && r <= A + D + 1) rx[r-A-2] = miso;
      sclk = 1'b0;
    end
    #40;
    if (!op && nrises >= NR && !reset_hit) check("miso_tail", vec_t'(miso), '0);
    ss = 1'b1;
    #80;
    commit = op && nrises == NW && !reset_hit;
    if (commit) begin
      if (addr < NREG) model[addr] = data;
      model_last_addr = addr;
    end
    check("stb_count", vec_t'(stb_cnt), vec_t'(commit));
    check("wr_addr", vec_t'(wr_addr), vec_t'(model_last_addr));
    if (!op && nrises >= NW && !reset_hit)
      check("rd_data", vec_t'(rx), vec_t'((addr < NREG) ? model[addr] : '0));
    $display("frame op=%0d addr=%0h data=%0h rises=%0d rst_at=%0d rx=%0h strobes=%0d",
             op, addr, data, nrises, rst_at, rx, stb_cnt);
    settled = 1'b1;
  endtask

  initial begin
    logic [D-1:0] rx;
    for (int k = 0; k < NREG; k++) model[k] = '0;
    #20;
    check("reset_regs", regs, '0);
    check("reset_miso", vec_t'(miso), '0);
    check("reset_stb", vec_t'(wr_stb), '0);
    check("reset_wr_addr", vec_t'(wr_addr), '0);
    rst = 1'b0;
    #100;
    settled = 1'b1;

    frame(1'b1, 8'h05, 8'hA5, NW, 0, rx);
    check("lit_reg5", vec_t'(regs[47:40]), vec_t'(8'hA5));
    check("lit_wr_addr5", vec_t'(wr_addr), vec_t'(8'h05));
    frame(1'b0, 8'h05, 8'h00, NR, 0, rx);
    check("lit_rd5", vec_t'(rx), vec_t'(8'hA5));

    frame(1'b1, 8'h20, 8'h3C, NW, 0, rx);
    check("lit_wr_addr20", vec_t'(wr_addr), vec_t'(8'h20));
    frame(1'b0, 8'h20, 8'h00, NR, 0, rx);
    check("lit_rd20", vec_t'(rx), '0);

    frame(1'b1, 8'h03, 8'h77, 12, 0, rx);
    check("lit_trunc_reg3", vec_t'(regs[31:24]), '0);
    frame(1'b1, 8'h03, 8'h77, NW, 0, rx);
    check("lit_reg3", vec_t'(regs[31:24]), vec_t'(8'h77));

    frame(1'b1, 8'h02, 8'h5A, NW, 10, rx);
    check("lit_rst_regs", regs, '0);
    frame(1'b1, 8'h02, 8'h11, NW, 0, rx);
    check("lit_reg2", vec_t'(regs[23:16]), vec_t'(8'h11));

    frame(1'b1, 8'h0F, 8'hFF, NW, 0, rx);
    frame(1'b0, 8'h0F, 8'h00, NR, 0, rx);
    check("lit_rd0f", vec_t'(rx), vec_t'(8'hFF));

    for (int n = 0; n < 30; n++) begin
      bit op;
      int len;
      op = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) < 7) ? (op ? NW : NR) : int'($urandom_range(0, A + D + 4));
      frame(op, 8'($urandom_range(0, 31)), 8'($urandom), len, 0, rx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
